// File: rtl/pc_sequencer_pkg.sv
// Shared codes for the program-counter sequencer: PC source selectors, branch
// types, exception causes and handler state.
package pc_sequencer_pkg;

    localparam logic [1:0] PCSRC_ALU_RESULT = 2'b00;
    localparam logic [1:0] PCSRC_JUMP       = 2'b01;
    localparam logic [1:0] PCSRC_ALU_OUT    = 2'b10;
    localparam logic [1:0] PCSRC_EPC        = 2'b11;

    localparam logic [1:0] BR_BEQ = 2'b00;
    localparam logic [1:0] BR_BNE = 2'b01;
    localparam logic [1:0] BR_BGT = 2'b10;
    localparam logic [1:0] BR_BLE = 2'b11;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_0        = 2'd0;
    localparam cause_t CAUSE_1        = 2'd1;
    localparam cause_t CAUSE_2        = 2'd2;
    localparam cause_t CAUSE_MISALIGN = 2'd3;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/datapath bundle between the control unit and the PC sequencer.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       branch_type;
    logic             alu_zero;
    logic             alu_gt;
    logic [1:0]       pcsrc_selector;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] alu_out_reg;
    logic             exc_req;
    logic [1:0]       exc_cause;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] epc;
    logic             in_handler;
    logic             exc_ack;
    logic             misaligned;
    logic             double_fault;

    modport master (
        output pc_write, pc_write_cond, branch_type, alu_zero, alu_gt,
               pcsrc_selector, alu_result, jump_target, alu_out_reg,
               exc_req, exc_cause,
        input  pc, epc, in_handler, exc_ack, misaligned, double_fault
    );

    modport slave (
        input  pc_write, pc_write_cond, branch_type, alu_zero, alu_gt,
               pcsrc_selector, alu_result, jump_target, alu_out_reg,
               exc_req, exc_cause,
        output pc, epc, in_handler, exc_ack, misaligned, double_fault
    );

endinterface

// File: rtl/pc_sequencer_branch_cond.sv
// Conditional-branch evaluation from the ALU flags.
module pc_branch_cond
    import pc_sequencer_pkg::*;
(
    input  logic [1:0] branch_type,
    input  logic       zero,
    input  logic       gt,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (branch_type)
            BR_BEQ:  cond = zero;
            BR_BNE:  cond = !zero;
            BR_BGT:  cond = gt;
            BR_BLE:  cond = !gt;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC/EPC unit: source mux, conditional writes, exception vectoring,
// alignment checking and handler-state tracking.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int          WIDTH           = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR    = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR_BASE = 'h0000_00FC,
    parameter int unsigned EPC_OFFSET      = 4,
    parameter bit          ALIGN_CHECK     = 1'b1,
    parameter cause_t      MISALIGN_CAUSE  = CAUSE_MISALIGN
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             ack_q, ack_d;
    logic             mis_q, mis_d;
    logic             df_q, df_d;

    logic [WIDTH-1:0] next_target;
    logic             cond;
    logic             take;
    logic             fault_align;
    logic             exc_any;
    cause_t           cause_sel;
    logic [WIDTH-1:0] exc_vector;

    pc_branch_cond u_branch_cond (
        .branch_type (bus.branch_type),
        .zero        (bus.alu_zero),
        .gt          (bus.alu_gt),
        .cond        (cond)
    );

    always_comb begin
        next_target = bus.alu_result;
        case (bus.pcsrc_selector)
            PCSRC_ALU_RESULT: next_target = bus.alu_result;
            PCSRC_JUMP:       next_target = bus.jump_target;
            PCSRC_ALU_OUT:    next_target = bus.alu_out_reg;
            PCSRC_EPC:        next_target = epc_q;
            default:          next_target = bus.alu_result;
        endcase
    end

    assign take        = bus.pc_write || (bus.pc_write_cond && cond);
    assign fault_align = ALIGN_CHECK && take && (next_target[1:0] != 2'b00);
    assign exc_any     = bus.exc_req || fault_align;
    // External request outranks an alignment fault in the same cycle
    assign cause_sel   = bus.exc_req ? bus.exc_cause : MISALIGN_CAUSE;
    assign exc_vector  = EXC_VECTOR_BASE + WIDTH'({cause_sel, 2'b00});

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        ack_d   = 1'b0;
        mis_d   = 1'b0;
        df_d    = df_q;
        if (exc_any) begin
            pc_d  = exc_vector;
            ack_d = 1'b1;
            mis_d = !bus.exc_req;
            case (state_q)
                ST_NORMAL: begin
                    epc_d   = pc_q - WIDTH'(EPC_OFFSET);
                    state_d = ST_HANDLER;
                end
                ST_HANDLER: df_d = 1'b1;
                default:    state_d = ST_NORMAL;
            endcase
        end else if (take) begin
            pc_d = next_target;
            if (state_q == ST_HANDLER && bus.pcsrc_selector == PCSRC_EPC) begin
                state_d = ST_NORMAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
            ack_q <= 1'b0;
            mis_q <= 1'b0;
            df_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            ack_q <= ack_d;
            mis_q <= mis_d;
            df_q  <= df_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.epc          = epc_q;
    assign bus.in_handler   = (state_q == ST_HANDLER);
    assign bus.exc_ack      = ack_q;
    assign bus.misaligned   = mis_q;
    assign bus.double_fault = df_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_epc;
    logic        m_inh, m_ack, m_mis, m_df;

    pc_sequencer_if #(.WIDTH(32)) bus ();

    pc_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("pc", bus.pc, m_pc);
        check("epc", bus.epc, m_epc);
        check("in_handler", 32'(bus.in_handler), 32'(m_inh));
        check("exc_ack", 32'(bus.exc_ack), 32'(m_ack));
        check("misaligned", 32'(bus.misaligned), 32'(m_mis));
        check("double_fault", 32'(bus.double_fault), 32'(m_df));
    endtask

    task automatic model_update();
        logic [31:0] tgt;
        logic        c, take, bad;
        logic [1:0]  cause;
        if (reset) begin
            m_pc = 32'h0; m_epc = 32'h0;
            m_inh = 0; m_ack = 0; m_mis = 0; m_df = 0;
            return;
        end
        tgt = (bus.pcsrc_selector == 0) ? bus.alu_result :
              (bus.pcsrc_selector == 1) ? bus.jump_target :
              (bus.pcsrc_selector == 2) ? bus.alu_out_reg : m_epc;
        c = (bus.branch_type == 0) ? bus.alu_zero :
            (bus.branch_type == 1) ? !bus.alu_zero :
            (bus.branch_type == 2) ? bus.alu_gt : !bus.alu_gt;
        take = bus.pc_write || (bus.pc_write_cond && c);
        bad  = take && (tgt % 4 != 0);
        if (bus.exc_req || bad) begin
            cause = bus.exc_req ? bus.exc_cause : 2'd3;
            if (m_inh) m_df = 1;
            else begin
                m_epc = m_pc - 4;
                m_inh = 1;
            end
            m_pc  = 32'd252 + 4 * 32'(cause);
            m_ack = 1;
            m_mis = !bus.exc_req;
        end else begin
            m_ack = 0;
            m_mis = 0;
            if (take) begin
                if (m_inh && bus.pcsrc_selector == 3) m_inh = 0;
                m_pc = tgt;
            end
        end
    endtask

    task automatic drive(input logic pw, input logic pwc, input logic [1:0] bt,
                         input logic z, input logic g, input logic [1:0] sel,
                         input logic [31:0] ar, input logic [31:0] jt, input logic [31:0] ao,
                         input logic exc, input logic [1:0] cause);
        bus.pc_write = pw;  bus.pc_write_cond = pwc; bus.branch_type = bt;
        bus.alu_zero = z;   bus.alu_gt = g;          bus.pcsrc_selector = sel;
        bus.alu_result = ar; bus.jump_target = jt;   bus.alu_out_reg = ao;
        bus.exc_req = exc;  bus.exc_cause = cause;
    endtask

    task automatic idle();
        drive(0, 0, 2'd0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 7) != 0) v[1:0] = 2'b00;
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        idle();
        tick();
        check("reset_pc", bus.pc, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        drive(1, 0, 2'd0, 0, 0, 2'd0, 32'h4, 32'h0, 32'h0, 0, 2'd0);
        tick();
        check("pc_write_alu", bus.pc, 32'h4);
        drive(0, 1, 2'd0, 0, 0, 2'd0, 32'h8, 32'h0, 32'h0, 0, 2'd0);
        tick();
        check("beq_not_taken", bus.pc, 32'h4);
        drive(0, 1, 2'd2, 0, 1, 2'd2, 32'h8, 32'h0, 32'h40, 0, 2'd0);
        tick();
        check("bgt_taken", bus.pc, 32'h40);
        drive(1, 0, 2'd0, 0, 0, 2'd0, 32'h44, 32'h0, 32'h0, 0, 2'd0);
        tick();
        drive(0, 0, 2'd0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 1, 2'd1);
        tick();
        check("exc_pc", bus.pc, 32'h100);
        check("exc_epc", bus.epc, 32'h40);
        check("exc_ack_pulse", 32'(bus.exc_ack), 32'h1);
        idle();
        tick();
        check("exc_ack_clear", 32'(bus.exc_ack), 32'h0);
        drive(1, 0, 2'd0, 0, 0, 2'd3, 32'h0, 32'h0, 32'h0, 0, 2'd0);
        tick();
        check("eret_pc", bus.pc, 32'h40);
        check("eret_inh", 32'(bus.in_handler), 32'h0);
        drive(1, 0, 2'd0, 0, 0, 2'd2, 32'h0, 32'h0, 32'h42, 0, 2'd0);
        tick();
        check("misalign_pc", bus.pc, 32'h108);
        check("misalign_epc", bus.epc, 32'h3C);
        check("misalign_pulse", 32'(bus.misaligned), 32'h1);
        drive(0, 0, 2'd0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 1, 2'd0);
        tick();
        check("dbl_pc", bus.pc, 32'hFC);
        check("dbl_epc", bus.epc, 32'h3C);
        check("dbl_flag", 32'(bus.double_fault), 32'h1);
        idle();
        for (int i = 0; i < 2; i++) tick();
        check("dbl_sticky", 32'(bus.double_fault), 32'h1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_clears_df", 32'(bus.double_fault), 32'h0);
        // Exception at pc=0 alongside a write: write suppressed, epc wraps
        drive(1, 0, 2'd0, 0, 0, 2'd0, 32'h80, 32'h0, 32'h0, 1, 2'd3);
        tick();
        check("wrap_pc", bus.pc, 32'h108);
        check("wrap_epc", bus.epc, 32'hFFFF_FFFC);
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        drive(1, 1, 2'd0, 0, 0, 2'd1, 32'h0, 32'h200, 32'h0, 0, 2'd0);
        tick();
        check("pw_beats_cond", bus.pc, 32'h200);

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  rand_target(), rand_target(), rand_target(),
                  ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
